pulse_peak_detector: RTL and testbench
======================================

# pulse_peak_detector

Pulse peak detector downstream of `exp_sig_gen`. It consumes one ADC-format sample per clock from `exp_sig_gen.output_data` and tracks a block-averaged baseline. It detects pulses that rise above the baseline by more than a programmable threshold. For each pulse it emits one record containing the baseline-subtracted peak amplitude, the peak timestamp and the pulse width, which closes the generator→filter test loop.

## Interface
Parameters:
- `SIZE_ADC_DATA`, default package value (14): sample width.
- `BL_LOG2`, default 4: baseline block length is 2^BL_LOG2 samples.
- `HOLDOFF`, default 8: dead-time cycles after each pulse.
- `SIZE_TS`, default 16: timestamp width.
- `SIZE_WIDTH`, default 12: pulse-width counter width.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: detector run; 0 forces INIT.
- `in_data` in SIZE_ADC_DATA: unsigned sample, one per clock.
- `threshold` in SIZE_ADC_DATA: trigger level above baseline.
- `peak_valid` out 1: one-cycle strobe, record valid.
- `peak_amp` out SIZE_ADC_DATA: max(in_data − baseline) over the pulse.
- `peak_time` out SIZE_TS: timestamp of the peak sample.
- `peak_width` out SIZE_WIDTH: number of samples above threshold.
- `baseline` out SIZE_ADC_DATA: current baseline.
- `busy` out 1: state is PULSE or HOLDOFF.

## Operation
- **Input stage.** `in_data` and the timestamp are registered together as x_r and ts_r.
- **Timestamp.** Free-running SIZE_TS counter. It increments every cycle while `enable` is high, holds while `enable` is low, and wraps to 0.
- **Difference.** diff = x_r − baseline. If the result is negative, diff is clamped to 0. diff is SIZE_ADC_DATA wide.
- **Baseline accumulator.** Width SIZE_ADC_DATA+BL_LOG2. It sums 2^BL_LOG2 consecutive samples only while in INIT or IDLE. When a block completes, baseline ← sum >> BL_LOG2 (truncating) and the accumulator is cleared. Leaving IDLE discards the partial block, and accumulation restarts on re-entering IDLE.
- **Threshold.** Compared live; a change takes effect on the next comparison. The trigger is strict: diff > threshold.

FSM:
- **INIT.** Accumulate the first block. On block completion, load `baseline` and go to IDLE. No triggering in this state.
- **IDLE.** If diff > threshold: go to PULSE, set peak ← diff, peak_t ← ts_r, width ← 1.
- **PULSE.**
  - If diff > threshold: width increments, saturating at all-ones. If diff > peak (strictly greater), update peak and peak_t; an equal plateau keeps the first timestamp.
  - Else: register the outputs, pulse `peak_valid`, and go to HOLDOFF. The terminating sample is not counted in width.
- **HOLDOFF.** Count HOLDOFF cycles, ignoring the input, then go to IDLE.
- **enable = 0.** From any state, go to INIT. Clear the accumulator. Emit no record. `baseline` holds its last value.

## Timing
- **Reset values.** All outputs are 0. State is INIT. Timestamp and accumulator are 0.
- **Record latency.** A terminating sample presented on `in_data` in cycle n produces `peak_valid` = 1 in cycle n+2 for exactly one cycle.
- **Record hold.** `peak_amp`, `peak_time` and `peak_width` are stable from the `peak_valid` cycle until the next record.
- **`peak_time` reference.** Equals the timestamp of the cycle in which the peak sample was on `in_data`.
- **Baseline update.** `baseline` updates 1 cycle after the last sample of a block is registered.
- **`busy`.** Registered from state; high from the cycle after the trigger until HOLDOFF expires.
- **Minimum record spacing.** 2 + HOLDOFF cycles.
- **Reset during PULSE or HOLDOFF.** No `peak_valid`; return to INIT.
- **Timestamp wrap inside a pulse.** Allowed; `peak_time` is the raw wrapped value.

## Structure
- **Shared package additions.**
  - Typedef `ppd_state_t` (INIT, IDLE, PULSE, HOLDOFF).
  - Constants SIZE_TS and SIZE_WIDTH.
  - SIZE_ADC_DATA is already present in the package.
- **Sub-module `baseline_avg`.** Contains the block accumulator, the block-length counter and the baseline register. Ports: `clk`, `reset`, `clr`, `acc_en`, `x`, `baseline`, `bl_update`.
- **Top level.** The FSM, the difference/clamp logic and the record registers.

## Test plan
- **Reset.** Assert `reset` for 3 cycles with `in_data` = 500 → all outputs 0, `busy` = 0. Without `enable`, `baseline` stays 0.
- **Flat input.** `enable` = 1, `in_data` = 100 for 40 cycles, `threshold` = 50 → `baseline` = 100 after 17 cycles, no `peak_valid`.
- **Single pulse.** After baseline 100, present 100, 200, 400, 300, 120, 100 with `threshold` = 50 → one `peak_valid`, 2 cycles after the 120 sample.
  - Expected record: `peak_amp` = 300, `peak_width` = 3, `peak_time` = timestamp of the 400 sample.
- **Negative excursion and plateau.**
  - Input 0 on baseline 100 → diff clamps to 0, no trigger.
  - Pulse 300, 300, 100 → `peak_amp` = 200, `peak_time` of the first 300, `peak_width` = 2.
- **Holdoff.**
  - Second pulse starting 3 cycles after `peak_valid`, with HOLDOFF = 8 → ignored.
  - Same pulse shape starting 12 cycles after → detected.
- **Reset or disable mid-pulse.** `reset` (or `enable` = 0) during PULSE → no `peak_valid`, state returns to INIT. `baseline` re-acquires after 2^BL_LOG2 samples once re-enabled.

Source files
------------

// File: rtl/pulse_peak_detector_pkg.sv
// Shared types and sizes for the pulse peak detector and its baseline averager.
// Nothing here generates logic; it is constants and the FSM state type only.
package pulse_peak_detector_pkg;

    localparam int SIZE_ADC_DATA = 14;
    localparam int SIZE_TS       = 16;
    localparam int SIZE_WIDTH    = 12;

    typedef enum logic [1:0] {
        PPD_INIT    = 2'd0,
        PPD_IDLE    = 2'd1,
        PPD_PULSE   = 2'd2,
        PPD_HOLDOFF = 2'd3
    } ppd_state_t;

endpackage

// File: rtl/pulse_peak_detector_baseline_avg.sv
// Block averager: sums 2^BL_LOG2 samples and loads baseline with the truncated mean.
// baseline is valid the cycle after the block's last sample; no backpressure, clr wins over acc_en.
module baseline_avg #(
    parameter int SIZE_ADC_DATA = pulse_peak_detector_pkg::SIZE_ADC_DATA,
    parameter int BL_LOG2       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic [SIZE_ADC_DATA-1:0] x,
    output logic [SIZE_ADC_DATA-1:0] baseline,
    output logic                     bl_update
);

    logic [SIZE_ADC_DATA+BL_LOG2-1:0] acc_q;
    logic [SIZE_ADC_DATA+BL_LOG2-1:0] sum_d;
    logic [BL_LOG2-1:0]               cnt_q;
    logic [SIZE_ADC_DATA-1:0]         bl_q;

    assign sum_d     = acc_q + {{BL_LOG2{1'b0}}, x};
    // Asserted in the cycle whose sample closes the block; the new mean appears next cycle.
    assign bl_update = acc_en && !clr && (cnt_q == '1);
    assign baseline  = bl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
            bl_q  <= '0;
        end else if (clr) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (acc_en) begin
            if (cnt_q == '1) begin
                bl_q  <= sum_d[SIZE_ADC_DATA+BL_LOG2-1:BL_LOG2];
                acc_q <= '0;
                cnt_q <= '0;
            end else begin
                acc_q <= sum_d;
                cnt_q <= cnt_q + BL_LOG2'(1);
            end
        end
    end

endmodule

// File: rtl/pulse_peak_detector.sv
// Detects pulses above a block-averaged baseline and emits peak amplitude/time/width records.
// Record strobes 2 cycles after the terminating sample; no backpressure, one sample every clock.
module pulse_peak_detector #(
    parameter int SIZE_ADC_DATA = pulse_peak_detector_pkg::SIZE_ADC_DATA,
    parameter int BL_LOG2       = 4,
    parameter int HOLDOFF       = 8,
    parameter int SIZE_TS       = pulse_peak_detector_pkg::SIZE_TS,
    parameter int SIZE_WIDTH    = pulse_peak_detector_pkg::SIZE_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [SIZE_ADC_DATA-1:0] in_data,
    input  logic [SIZE_ADC_DATA-1:0] threshold,
    output logic                     peak_valid,
    output logic [SIZE_ADC_DATA-1:0] peak_amp,
    output logic [SIZE_TS-1:0]       peak_time,
    output logic [SIZE_WIDTH-1:0]    peak_width,
    output logic [SIZE_ADC_DATA-1:0] baseline,
    output logic                     busy
);

    import pulse_peak_detector_pkg::*;

    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    logic [SIZE_ADC_DATA-1:0] x_q;
    logic [SIZE_TS-1:0]       ts_q;
    logic [SIZE_TS-1:0]       ts_d;
    logic [SIZE_TS-1:0]       ts_r_q;
    logic                     x_vld_q;

    ppd_state_t               state_q;
    logic [SIZE_ADC_DATA-1:0] peak_q;
    logic [SIZE_TS-1:0]       peak_t_q;
    logic [SIZE_WIDTH-1:0]    width_q;
    logic [SIZE_WIDTH-1:0]    width_d;
    logic [HO_W-1:0]          ho_cnt_q;

    logic                     peak_valid_q;
    logic [SIZE_ADC_DATA-1:0] peak_amp_q;
    logic [SIZE_TS-1:0]       peak_time_q;
    logic [SIZE_WIDTH-1:0]    peak_width_q;
    logic                     busy_q;

    logic [SIZE_ADC_DATA-1:0] baseline_w;
    logic [SIZE_ADC_DATA-1:0] diff;
    logic                     trig;
    logic                     acc_en;
    logic                     acc_clr;
    logic                     bl_update;

    assign ts_d = ts_q + SIZE_TS'(1);

    // x_vld_q marks x_q as a sample taken while running, so a stale
    // pre-enable value never lands in the first baseline block.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= '0;
            ts_q    <= '0;
            ts_r_q  <= '0;
            x_vld_q <= 1'b0;
        end else begin
            x_q     <= in_data;
            ts_r_q  <= ts_q;
            x_vld_q <= enable;
            if (enable) begin
                ts_q <= ts_d;
            end
        end
    end

    assign diff    = (x_q >= baseline_w) ? (x_q - baseline_w) : '0;
    assign trig    = diff > threshold;
    assign width_d = (width_q == '1) ? width_q : (width_q + SIZE_WIDTH'(1));

    assign acc_en  = enable && x_vld_q && ((state_q == PPD_INIT) || (state_q == PPD_IDLE));
    assign acc_clr = !enable || (state_q == PPD_PULSE) || (state_q == PPD_HOLDOFF)
                   || ((state_q == PPD_IDLE) && trig);

    baseline_avg #(
        .SIZE_ADC_DATA (SIZE_ADC_DATA),
        .BL_LOG2       (BL_LOG2)
    ) u_baseline_avg (
        .clk       (clk),
        .reset     (reset),
        .clr       (acc_clr),
        .acc_en    (acc_en),
        .x         (x_q),
        .baseline  (baseline_w),
        .bl_update (bl_update)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= PPD_INIT;
            peak_q       <= '0;
            peak_t_q     <= '0;
            width_q      <= '0;
            ho_cnt_q     <= '0;
            peak_valid_q <= 1'b0;
            peak_amp_q   <= '0;
            peak_time_q  <= '0;
            peak_width_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            if (!enable) begin
                state_q <= PPD_INIT;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    PPD_INIT: begin
                        if (bl_update) begin
                            state_q <= PPD_IDLE;
                        end
                    end
                    PPD_IDLE: begin
                        if (trig) begin
                            state_q  <= PPD_PULSE;
                            busy_q   <= 1'b1;
                            peak_q   <= diff;
                            peak_t_q <= ts_r_q;
                            width_q  <= SIZE_WIDTH'(1);
                        end
                    end
                    PPD_PULSE: begin
                        if (trig) begin
                            width_q <= width_d;
                            // Strict compare: a flat top keeps its first timestamp.
                            if (diff > peak_q) begin
                                peak_q   <= diff;
                                peak_t_q <= ts_r_q;
                            end
                        end else begin
                            state_q      <= PPD_HOLDOFF;
                            ho_cnt_q     <= '0;
                            peak_valid_q <= 1'b1;
                            peak_amp_q   <= peak_q;
                            peak_time_q  <= peak_t_q;
                            peak_width_q <= width_q;
                        end
                    end
                    PPD_HOLDOFF: begin
                        if (ho_cnt_q == HO_W'(HOLDOFF - 1)) begin
                            state_q <= PPD_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ho_cnt_q <= ho_cnt_q + HO_W'(1);
                        end
                    end
                    default: begin
                        state_q <= PPD_INIT;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign peak_valid = peak_valid_q;
    assign peak_amp   = peak_amp_q;
    assign peak_time  = peak_time_q;
    assign peak_width = peak_width_q;
    assign baseline   = baseline_w;
    assign busy       = busy_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed plus randomized bench for pulse_peak_detector with a sample-level reference model.
module tb_pulse_peak_detector;

    localparam int W   = 14;
    localparam int BL  = 4;
    localparam int HO  = 8;
    localparam int TSW = 16;
    localparam int WW  = 12;
    localparam int BLK = 1 << BL;
    localparam int WMAX = (1 << WW) - 1;

    localparam int M_INIT = 0;
    localparam int M_IDLE = 1;
    localparam int M_PULSE = 2;
    localparam int M_HOLD = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           enable;
    logic [W-1:0]   in_data;
    logic [W-1:0]   threshold;
    logic           peak_valid;
    logic [W-1:0]   peak_amp;
    logic [TSW-1:0] peak_time;
    logic [WW-1:0]  peak_width;
    logic [W-1:0]   baseline;
    logic           busy;

    pulse_peak_detector #(
        .SIZE_ADC_DATA (W),
        .BL_LOG2       (BL),
        .HOLDOFF       (HO),
        .SIZE_TS       (TSW),
        .SIZE_WIDTH    (WW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_data    (in_data),
        .threshold  (threshold),
        .peak_valid (peak_valid),
        .peak_amp   (peak_amp),
        .peak_time  (peak_time),
        .peak_width (peak_width),
        .baseline   (baseline),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int valid_seen = 0;

    // Reference model: expected outputs after each clock edge.
    int m_mode = M_INIT;
    int m_base = 0, m_amp = 0, m_time = 0, m_width = 0;
    bit m_valid = 1'b0, m_busy = 1'b0;
    int m_ts = 0;
    int p_d = 0, p_ts = 0;
    bit p_vld = 1'b0;
    int blk[$];
    int pk_diff[$];
    int pk_ts[$];
    int edge_n = 0;
    int rec_edge = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic add_sample(input int v);
        int sum;
        blk.push_back(v);
        if (blk.size() == BLK) begin
            sum = 0;
            foreach (blk[i]) sum += blk[i];
            m_base = sum / BLK;
            blk.delete();
            m_mode = M_IDLE;
        end
    endtask

    task automatic close_pulse();
        int best;
        best = 0;
        for (int i = 1; i < pk_diff.size(); i++) begin
            if (pk_diff[i] > pk_diff[best]) best = i;
        end
        m_amp   = pk_diff[best];
        m_time  = pk_ts[best];
        m_width = (pk_diff.size() > WMAX) ? WMAX : pk_diff.size();
        m_valid = 1'b1;
        m_mode  = M_HOLD;
        rec_edge = edge_n;
        pk_diff.delete();
        pk_ts.delete();
    endtask

    task automatic model_edge(input int d, input bit en, input bit rst, input int thr);
        int diff;
        bit trig;
        edge_n++;
        if (rst) begin
            m_mode = M_INIT; m_base = 0; m_amp = 0; m_time = 0; m_width = 0;
            m_valid = 1'b0; m_busy = 1'b0; m_ts = 0; p_d = 0; p_ts = 0; p_vld = 1'b0;
            blk.delete(); pk_diff.delete(); pk_ts.delete();
        end else begin
            m_valid = 1'b0;
            if (!en) begin
                m_mode = M_INIT;
                m_busy = 1'b0;
                blk.delete(); pk_diff.delete(); pk_ts.delete();
            end else begin
                diff = (p_d > m_base) ? p_d - m_base : 0;
                trig = diff > thr;
                case (m_mode)
                    M_INIT: if (p_vld) add_sample(p_d);
                    M_IDLE: begin
                        if (trig) begin
                            blk.delete();
                            pk_diff.push_back(diff);
                            pk_ts.push_back(p_ts);
                            m_mode = M_PULSE;
                            m_busy = 1'b1;
                        end else begin
                            add_sample(p_d);
                        end
                    end
                    M_PULSE: begin
                        if (trig) begin
                            pk_diff.push_back(diff);
                            pk_ts.push_back(p_ts);
                        end else begin
                            close_pulse();
                        end
                    end
                    default: begin
                        if (edge_n - rec_edge == HO) begin
                            m_mode = M_IDLE;
                            m_busy = 1'b0;
                        end
                    end
                endcase
            end
            p_d = d;
            p_ts = m_ts;
            p_vld = en;
            if (en) m_ts = (m_ts + 1) % (1 << TSW);
        end
    endtask

    task automatic tick(input int d, input bit en, input bit rst);
        in_data = d[W-1:0];
        enable = en;
        reset = rst;
        @(posedge clk);
        model_edge(d, en, rst, int'(threshold));
        #1;
        if (peak_valid === 1'b1) valid_seen++;
        chk("peak_valid", 32'(peak_valid), 32'(m_valid));
        chk("peak_amp", 32'(peak_amp), m_amp);
        chk("peak_time", 32'(peak_time), m_time);
        chk("peak_width", 32'(peak_width), m_width);
        chk("baseline", 32'(baseline), m_base);
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    initial begin
        int v0, t_pk, lvl, len, amp, base_now;
        reset = 1'b1;
        enable = 1'b0;
        in_data = '0;
        threshold = W'(50);

        // Reset with 500 on the input, then idle without enable.
        for (int i = 0; i < 3; i++) tick(500, 1'b0, 1'b1);
        chk("rst_amp", 32'(peak_amp), 0);
        chk("rst_busy", 32'(busy), 0);
        for (int i = 0; i < 5; i++) tick(500, 1'b0, 1'b0);
        chk("noen_base", 32'(baseline), 0);

        // Flat input: baseline appears after 17 cycles.
        for (int i = 0; i < 16; i++) tick(100, 1'b1, 1'b0);
        chk("flat_base16", 32'(baseline), 0);
        tick(100, 1'b1, 1'b0);
        chk("flat_base17", 32'(baseline), 100);
        v0 = valid_seen;
        for (int i = 0; i < 23; i++) tick(100, 1'b1, 1'b0);
        chk("flat_novalid", valid_seen - v0, 0);

        // Single pulse.
        v0 = valid_seen;
        tick(100, 1'b1, 1'b0);
        tick(200, 1'b1, 1'b0);
        t_pk = m_ts;
        tick(400, 1'b1, 1'b0);
        tick(300, 1'b1, 1'b0);
        tick(120, 1'b1, 1'b0);
        chk("pulse_early", 32'(peak_valid), 0);
        tick(100, 1'b1, 1'b0);
        chk("pulse_valid", 32'(peak_valid), 1);
        chk("pulse_amp", 32'(peak_amp), 300);
        chk("pulse_width", 32'(peak_width), 3);
        chk("pulse_time", 32'(peak_time), t_pk);
        for (int i = 0; i < 12; i++) tick(100, 1'b1, 1'b0);
        chk("pulse_count", valid_seen - v0, 1);
        chk("pulse_hold_amp", 32'(peak_amp), 300);

        // Negative excursion, then a plateau.
        v0 = valid_seen;
        tick(0, 1'b1, 1'b0);
        tick(100, 1'b1, 1'b0);
        tick(100, 1'b1, 1'b0);
        chk("neg_busy", 32'(busy), 0);
        base_now = int'(baseline);
        t_pk = m_ts;
        tick(300, 1'b1, 1'b0);
        tick(300, 1'b1, 1'b0);
        tick(100, 1'b1, 1'b0);
        tick(100, 1'b1, 1'b0);
        chk("plat_valid", 32'(peak_valid), 1);
        chk("plat_amp", 32'(peak_amp), 300 - base_now);
        chk("plat_time", 32'(peak_time), t_pk);
        chk("plat_width", 32'(peak_width), 2);

        // Holdoff: pulse at +3 ignored, same pulse at +12 detected.
        v0 = valid_seen;
        for (int i = 0; i < 3; i++) tick(100, 1'b1, 1'b0);
        tick(300, 1'b1, 1'b0);
        tick(300, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) tick(100, 1'b1, 1'b0);
        tick(300, 1'b1, 1'b0);
        tick(300, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++) tick(100, 1'b1, 1'b0);
        chk("holdoff_count", valid_seen - v0, 1);

        // Reset mid-pulse.
        v0 = valid_seen;
        tick(300, 1'b1, 1'b0);
        tick(300, 1'b1, 1'b0);
        chk("midrst_busy", 32'(busy), 1);
        tick(300, 1'b1, 1'b1);
        for (int i = 0; i < 17; i++) tick(100, 1'b1, 1'b0);
        chk("midrst_base", 32'(baseline), 100);
        for (int i = 0; i < 8; i++) tick(100, 1'b1, 1'b0);
        chk("midrst_novalid", valid_seen - v0, 0);

        // Disable mid-pulse.
        v0 = valid_seen;
        tick(300, 1'b1, 1'b0);
        tick(300, 1'b1, 1'b0);
        tick(300, 1'b0, 1'b0);
        tick(300, 1'b0, 1'b0);
        chk("dis_base_hold", 32'(baseline), 100);
        for (int i = 0; i < 25; i++) tick(100, 1'b1, 1'b0);
        chk("dis_novalid", valid_seen - v0, 0);

        // Width saturation on a very long pulse.
        for (int i = 0; i < WMAX + 5; i++) tick(200, 1'b1, 1'b0);
        tick(100, 1'b1, 1'b0);
        tick(100, 1'b1, 1'b0);
        chk("sat_width", 32'(peak_width), WMAX);
        chk("sat_amp", 32'(peak_amp), 100);
        for (int i = 0; i < 10; i++) tick(100, 1'b1, 1'b0);

        // Randomized baselines, thresholds, pulses, disables and resets.
        for (int it = 0; it < 60; it++) begin
            threshold = W'($urandom_range(200, 20));
            lvl = $urandom_range(3000, 50);
            len = $urandom_range(40, 0);
            for (int i = 0; i < len; i++) tick(lvl + $urandom_range(3, 0), 1'b1, 1'b0);
            len = $urandom_range(8, 1);
            for (int i = 0; i < len; i++) begin
                amp = lvl + $urandom_range(3000, 0);
                tick(amp, 1'b1, 1'b0);
            end
            len = $urandom_range(20, 2);
            for (int i = 0; i < len; i++) tick(lvl + $urandom_range(3, 0), 1'b1, 1'b0);
            if ($urandom_range(9, 0) == 0) begin
                len = $urandom_range(3, 1);
                for (int i = 0; i < len; i++) tick(lvl, 1'b0, 1'b0);
            end
            if ($urandom_range(19, 0) == 0) tick(lvl, 1'b1, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
